// File: rtl/lsb_rs_pkg.sv
// Shared types and widths for the load/store reservation station.
// Holds the entry record and the helpers the station and its bench use.
package lsb_rs_pkg;

    localparam int ROB_ID_W      = 5;
    localparam int XLEN          = 32;
    localparam int DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic                valid;
        logic [ROB_ID_W-1:0] rob_id;
        logic                qj_valid;
        logic [ROB_ID_W-1:0] qj;
        logic [XLEN-1:0]     vj;
        logic [XLEN-1:0]     imm;
    } rs_entry_t;

    function automatic logic entry_ready(input rs_entry_t e);
        return e.valid & ~e.qj_valid;
    endfunction

    // Effective address: a plain 32-bit add with the carry out discarded.
    function automatic logic [XLEN-1:0] agen(input logic [XLEN-1:0] base,
                                             input logic [XLEN-1:0] imm);
        return base + imm;
    endfunction

endpackage

// File: rtl/lsb_rs_select.sv
// Priority picker: returns the lowest-index set request bit and a found flag.
// It is used both to find a free slot and to find a ready entry.
module lsb_rs_select #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scanning downward lets the lowest set bit win the final assignment.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsb_rs_issue.sv
// Memory-op reservation station feeding the LSB address ALU.
// Optional macro LSB_RS_ISSUE_BYPASS_EN lets a ready dispatch skip the entry array.
module lsb_rs_issue
    import lsb_rs_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                _clear,
    input  logic                _dispatch_valid,
    input  logic [ROB_ID_W-1:0] _dispatch_rob_id,
    input  logic                _dispatch_qj_valid,
    input  logic [ROB_ID_W-1:0] _dispatch_qj,
    input  logic [XLEN-1:0]     _dispatch_vj,
    input  logic [XLEN-1:0]     _dispatch_imm,
    output logic                _rs_full,
    input  logic                _cdb_valid,
    input  logic [ROB_ID_W-1:0] _cdb_rob_id,
    input  logic [XLEN-1:0]     _cdb_value,
    input  logic                _alu_full,
    output logic                _alu_ready,
    output logic [ROB_ID_W-1:0] _alu_rob_id,
    output logic [XLEN-1:0]     _alu_value
);

    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] ready_vec;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             free_found;
    logic             sel_found;

    logic             disp_cdb_hit;
    logic             disp_qj_valid;
    logic [XLEN-1:0]  disp_vj;
    logic             disp_accept;
    logic             issue_fire;
    logic             direct_issue;

    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries[i].valid;
            ready_vec[i] = entry_ready(entries[i]);
        end
    end

    assign _rs_full = &valid_vec;

    lsb_rs_select #(.N(DEPTH), .IDX_W(IDX_W)) u_free_sel (
        .req   (~valid_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    lsb_rs_select #(.N(DEPTH), .IDX_W(IDX_W)) u_ready_sel (
        .req   (ready_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // A producer broadcasting in the dispatch cycle would otherwise be missed forever.
    assign disp_cdb_hit  = _cdb_valid & _dispatch_qj_valid & (_cdb_rob_id == _dispatch_qj);
    assign disp_qj_valid = _dispatch_qj_valid & ~disp_cdb_hit;
    assign disp_vj       = disp_cdb_hit ? _cdb_value : _dispatch_vj;

    assign disp_accept = _dispatch_valid & free_found;
    assign issue_fire  = sel_found & ~_alu_full;

`ifdef LSB_RS_ISSUE_BYPASS_EN
    assign direct_issue = disp_accept & ~disp_qj_valid & ~sel_found & ~_alu_full;
`else
    assign direct_issue = 1'b0;
`endif

    // Free-slot search uses pre-edge state, so a slot freed by issue waits a cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            _alu_ready  <= 1'b0;
            _alu_rob_id <= '0;
            _alu_value  <= '0;
        end else if (rdy_in) begin
            if (_clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i].valid <= 1'b0;
                end
                _alu_ready <= 1'b0;
            end else begin
                _alu_ready <= 1'b0;

                for (int i = 0; i < DEPTH; i++) begin
                    if (entries[i].valid && entries[i].qj_valid &&
                        _cdb_valid && (entries[i].qj == _cdb_rob_id)) begin
                        entries[i].qj_valid <= 1'b0;
                        entries[i].vj       <= _cdb_value;
                    end
                end

                if (issue_fire) begin
                    entries[sel_idx].valid <= 1'b0;
                    _alu_ready  <= 1'b1;
                    _alu_rob_id <= entries[sel_idx].rob_id;
                    _alu_value  <= agen(entries[sel_idx].vj, entries[sel_idx].imm);
                end else if (direct_issue) begin
                    _alu_ready  <= 1'b1;
                    _alu_rob_id <= _dispatch_rob_id;
                    _alu_value  <= agen(disp_vj, _dispatch_imm);
                end

                if (disp_accept && !direct_issue) begin
                    entries[free_idx] <= '{valid:    1'b1,
                                           rob_id:   _dispatch_rob_id,
                                           qj_valid: disp_qj_valid,
                                           qj:       _dispatch_qj,
                                           vj:       disp_vj,
                                           imm:      _dispatch_imm};
                end
            end
        end
    end

endmodule

// File: doc/lsb_rs_issue.md
# lsb_rs_issue

Memory-op reservation station feeding the load/store address ALU. Holds dispatched loads/stores until their base-register operand is available, snoops the CDB for wakeups, and issues one ready entry per cycle as (ROB id, base+imm) on the ALU request interface, honouring the ALU's full backpressure. It sits between dispatch and the LSB address ALU.

## Interface
- DEPTH, 8: number of entries (power of two, 2..16)
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-high
- rdy_in  input  1  global ready; all state and outputs freeze while low
- _clear  input  1  synchronous flush (misprediction)
- _dispatch_valid  input  1  new memory op this cycle
- _dispatch_rob_id  input  5  ROB id of the op
- _dispatch_qj_valid  input  1  base operand still pending
- _dispatch_qj  input  5  ROB id producing the base operand
- _dispatch_vj  input  32  base value (valid when qj_valid=0)
- _dispatch_imm  input  32  sign-extended offset
- _rs_full  output  1  all entries occupied
- _cdb_valid  input  1  CDB broadcast valid
- _cdb_rob_id  input  5  broadcasting ROB id
- _cdb_value  input  32  broadcast result
- _alu_full  input  1  ALU cannot accept a request this cycle
- _alu_ready  output  1  issue strobe, one cycle per issued op
- _alu_rob_id  output  5  ROB id of issued op
- _alu_value  output  32  vj + imm, modulo 2^32

## Operation
- Entry fields: valid, rob_id, qj_valid, qj, vj, imm. Entry ready = valid & !qj_valid.
- Allocation: dispatch writes the lowest-index free entry. Dispatch while _rs_full is ignored (upstream must not do it).
- _rs_full = all entries valid; combinational from registered state only.
- Dispatch-time bypass (mandatory): if _cdb_valid and _dispatch_qj_valid and _cdb_rob_id == _dispatch_qj, the entry is written with qj_valid=0, vj=_cdb_value.
- Wakeup: every pending entry with qj == _cdb_rob_id under _cdb_valid captures vj and clears qj_valid at the edge.
- Select: lowest-index ready entry. Issue occurs when a ready entry exists, _alu_full=0, rdy_in=1; entry is freed at the same edge.
- A slot freed at edge E is not reusable by a dispatch sampled at E.
- Address: 32-bit add, carry discarded.
- _clear (rdy_in=1): all entries invalidated, _alu_ready low after the edge; same-cycle dispatch and issue dropped.
- rdy_in=0: no state change, CDB and dispatch ignored, outputs hold; consumer gates on rdy_in identically.

## Timing
- Reset (async): all entries invalid, _alu_ready=0, _alu_rob_id=0, _alu_value=0, _rs_full=0.
- Issue outputs are registered. Op dispatched ready at edge E0: _alu_ready visible after E1 (1-cycle latency from write).
- Wakeup at edge E: entry eligible for selection in the following cycle; _alu_ready earliest after E+1.
- _alu_full high in cycle C: no issue at end of C; _alu_ready low in C+1. Sustained throughput one op per cycle.
- _alu_ready is high for exactly the cycles following issue edges; rob_id/value hold their last values otherwise.

## Configuration
- LSB_RS_ISSUE_BYPASS_EN defined: a dispatch whose operand is ready (directly or via CDB bypass) with no stored ready entry and _alu_full=0 goes straight to the output registers at E0 without occupying an entry; _alu_ready visible after E0.
- Undefined: every op is written into an entry first; latency as in Timing.

## Structure
- Package lsb_rs_pkg: ROB_ID_W=5, XLEN=32, DEPTH default, entry struct typedef.
- Sub-module lsb_rs_select: priority picker returning lowest-index set bit and a found flag; reused for free-slot and ready-entry search.

## Test plan
- Dispatch rob 3, vj=0x1000, imm=0xFFFFFFFC, qj_valid=0, _alu_full=0 -> one _alu_ready pulse, rob_id=3, value=0x00000FFC (without bypass macro: after E1).
- Dispatch rob 5 waiting on qj=2; CDB rob 2 value 0x20 two cycles later; imm=4 -> issue rob 5, value 0x24, the cycle after wakeup+1.
- Dispatch with qj=7 while CDB broadcasts rob 7 value 0x80, imm=0 -> entry stored ready, issues value 0x80, never stalls.
- Fill 8 ready entries with _alu_full=1 -> _rs_full=1, no _alu_ready; release _alu_full -> 8 consecutive pulses in index order, _rs_full drops after first issue.
- Four entries pending, assert _clear together with a dispatch -> all freed, no issue ever appears for them or the dropped dispatch.
- Pulse rst_in mid-issue between edges -> _alu_ready and _rs_full go 0 immediately; rdy_in=0 for 3 cycles with CDB traffic -> state and outputs unchanged.
